input_shift_stage: RTL and testbench
====================================

Name: input_shift_stage

Overview:
- Front-end stage that generates the A, B, C, D operand bits consumed by Main_Module.
- Takes a raw serial data line `din` and a raw push-button `btn`.
- Synchronizes both, then debounces `btn`.
- Each clean press shifts `din` into a 4-bit register, moving left to right: new bit → A → B → C → D.
- Flags when a full 4-bit frame has been entered.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronizers on `din` and `btn` (minimum 2).
- DEB_CYCLES, 16, consecutive stable cycles required to accept a press or a release (minimum 2).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- din  input  1  raw serial data bit, asynchronous to clk
- btn  input  1  raw shift push-button, asynchronous to clk, active high
- clr  input  1  synchronous clear of the shift register and frame counter
- A    output 1  newest bit (leftmost)
- B    output 1  bit shifted one position from A
- C    output 1  bit shifted two positions from A
- D    output 1  oldest bit (rightmost)
- frame_valid   output 1  high while 4 bits have been entered since the last restart
- frame_strobe  output 1  one-cycle pulse on the cycle frame_valid rises

Behaviour:
- Reset (asynchronous, active-high): all synchronizer flops, A–D, the frame counter, frame_valid, frame_strobe and the debounce counter go to 0; the debounce FSM goes to IDLE. Every output is 0 during and immediately after reset.
- Synchronizers: `din` and `btn` each pass through SYNC_STAGES flops, producing din_s and btn_s. No other logic touches the raw inputs.
- Debounce FSM states and transitions:
  - IDLE: if btn_s=1, go to ARM and clear the counter.
  - ARM: while btn_s=1, increment the counter. If btn_s=0, return to IDLE. When counter=DEB_CYCLES-1 with btn_s=1, go to PRESSED and assert shift_pulse for exactly that one cycle.
  - PRESSED: if btn_s=0, go to RELEASE and clear the counter. Holding the button never produces a second pulse.
  - RELEASE: while btn_s=0, increment the counter. When counter=DEB_CYCLES-1, go to IDLE. If btn_s=1, return to PRESSED with no pulse.
- Latency: a clean `btn` rise reaches A after SYNC_STAGES+DEB_CYCLES+1 cycles (±1 for input phase).
- Shift: on a shift_pulse cycle, the register update is A<=din_s, B<=A, C<=B, D<=C. din_s is sampled in the pulse cycle.
- Frame counter (3 bits, range 0..4):
  - On a shift: count<=1 if count==4, otherwise count+1.
  - frame_valid = registered (count==4).
  - frame_strobe = 1 for one cycle when count moves from 3 to 4.
  - A shift issued while frame_valid=1 starts a new frame: frame_valid drops, A–D keep shifting normally, and no wrap-around of data occurs.
- clr: synchronous. Next cycle A–D=0, count=0, frame_valid=0, frame_strobe=0. If clr and shift_pulse occur in the same cycle, clr wins and the pulse is discarded. clr does not affect the debounce FSM.
- Reset during operation: any partial frame is lost. If btn is still held after reset release, the FSM re-qualifies it through IDLE→ARM and produces one pulse after DEB_CYCLES. This is the defined behaviour.
- A–D only change on shift or clr, so the downstream combinational path sees stable values.

Decomposition:
- Package input_stage_pkg:
  - Debounce state enum: IDLE, ARM, PRESSED, RELEASE.
  - FRAME_LEN=4.
  - Counter width derived from DEB_CYCLES by a clog2 function.
- Sub-module debounce_fsm (clk, rst, btn_s → shift_pulse) holds the FSM and counter.
- The top level holds the synchronizers, the shift register and the frame counter.

Test Plan (SYNC_STAGES=2, DEB_CYCLES=4):
1. Assert rst with btn=1, din=1 → A–D, frame_valid and frame_strobe are all 0 throughout reset. After release, exactly one shift occurs, DEB_CYCLES after sync.
2. btn high for 2 cycles, then low for 10 → no shift_pulse; A–D unchanged at 0; FSM back in IDLE.
3. Four clean presses with din=1,0,1,1 → after the 4th: A=1, B=1, C=0, D=1; frame_valid=1; frame_strobe high for exactly 1 cycle.
4. Button held high for 50 cycles, with 1-cycle bounce glitches on release → exactly one shift total.
5. After scenario 3, a 5th press with din=0 → A=0, B=1, C=1, D=0; count=1; frame_valid=0; no frame_strobe.
6. clr in the same cycle as shift_pulse → next cycle A–D=0 and count=0; the pulse is discarded. A following press loads din into A with count=1.

Source files
------------

// File: rtl/input_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | input_stage_pkg                                                      |
// | Shared types and sizing helpers for the input shift stage.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package input_stage_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    PRESSED = 2'd2,
    RELEASE = 2'd3
  } deb_state_t;

  localparam int FRAME_LEN   = 4;
  localparam int FRAME_CNT_W = 3;

  // Bits needed to hold 0..value-1, never narrower than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w = w + 1;
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debounce_fsm                                                         |
// | Qualifies a synchronized button; one shift_pulse per clean press.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module debounce_fsm
  import input_stage_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_s,
  output logic shift_pulse
);

  localparam int CNT_W = clog2_min1(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = ARM;
          cnt_d   = '0;
        end
      end
      ARM: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = PRESSED;
          shift_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        // A bounce back high during release is treated as the same press.
        if (btn_s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/input_shift_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | input_shift_stage                                                    |
// | Syncs din/btn, debounces btn, shifts din into A..D, tracks frames.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module input_shift_stage
  import input_stage_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic btn,
  input  logic clr,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic frame_valid,
  output logic frame_strobe
);

  localparam logic [FRAME_CNT_W-1:0] CNT_FULL = FRAME_CNT_W'(FRAME_LEN);

  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
  logic [FRAME_LEN-1:0]   shift_q, shift_d;
  logic [FRAME_CNT_W-1:0] count_q, count_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   frame_strobe_q, frame_strobe_d;
  logic                   din_s, btn_s, shift_pulse;

  assign din_s = din_sync_q[SYNC_STAGES-1];
  assign btn_s = btn_sync_q[SYNC_STAGES-1];

  debounce_fsm #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk         (clk),
    .rst         (rst),
    .btn_s       (btn_s),
    .shift_pulse (shift_pulse)
  );

  always_comb begin
    din_sync_d     = {din_sync_q[SYNC_STAGES-2:0], din};
    btn_sync_d     = {btn_sync_q[SYNC_STAGES-2:0], btn};
    shift_d        = shift_q;
    count_d        = count_q;
    frame_strobe_d = 1'b0;
    // clr takes priority, so a coincident pulse is simply dropped.
    if (clr) begin
      shift_d = '0;
      count_d = '0;
    end else if (shift_pulse) begin
      shift_d        = {din_s, shift_q[FRAME_LEN-1:1]};
      count_d        = (count_q == CNT_FULL) ? FRAME_CNT_W'(1) : count_q + 1'b1;
      frame_strobe_d = (count_q == CNT_FULL - 1'b1);
    end
    frame_valid_d = (count_d == CNT_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_sync_q     <= '0;
      btn_sync_q     <= '0;
      shift_q        <= '0;
      count_q        <= '0;
      frame_valid_q  <= 1'b0;
      frame_strobe_q <= 1'b0;
    end else begin
      din_sync_q     <= din_sync_d;
      btn_sync_q     <= btn_sync_d;
      shift_q        <= shift_d;
      count_q        <= count_d;
      frame_valid_q  <= frame_valid_d;
      frame_strobe_q <= frame_strobe_d;
    end
  end

  assign A            = shift_q[FRAME_LEN-1];
  assign B            = shift_q[FRAME_LEN-2];
  assign C            = shift_q[FRAME_LEN-3];
  assign D            = shift_q[FRAME_LEN-4];
  assign frame_valid  = frame_valid_q;
  assign frame_strobe = frame_strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_input_shift_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_input_shift_stage                                                 |
// | Directed bench for input_shift_stage (SYNC_STAGES=2, DEB_CYCLES=4).  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_input_shift_stage;
  import input_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b1;
  logic btn = 1'b1;
  logic clr = 1'b0;
  logic A, B, C, D, frame_valid, frame_strobe;

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;
  int strobe_base;

  input_shift_stage #(
    .SYNC_STAGES (2),
    .DEB_CYCLES  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .btn          (btn),
    .clr          (clr),
    .A            (A),
    .B            (B),
    .C            (C),
    .D            (D),
    .frame_valid  (frame_valid),
    .frame_strobe (frame_strobe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_strobe === 1'b1) strobe_cnt = strobe_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks = checks + 1;
    assert (got === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic bit_in);
    din = bit_in;
    btn = 1'b1;
    tick(10);
    btn = 1'b0;
    tick(12);
  endtask

  initial begin
    // Reset held with button and data high: everything must stay at zero.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_abcd", {4'b0, A, B, C, D}, 8'h00);
      check("rst_flags", {6'b0, frame_valid, frame_strobe}, 8'h00);
    end
    rst = 1'b0;
    tick(6);
    check("rst_lat_pre", {7'b0, A}, 8'h00);
    tick(1);
    check("rst_lat_shift", {4'b0, A, B, C, D}, 8'h08);
    tick(10);
    btn = 1'b0;
    tick(12);
    check("rst_one_shift", {4'b0, A, B, C, D}, 8'h08);

    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_abcd", {4'b0, A, B, C, D}, 8'h00);
    check("clr_count", {5'b0, dut.count_q}, 8'h00);

    // Short 2-cycle press is rejected.
    btn = 1'b1;
    tick(2);
    btn = 1'b0;
    tick(10);
    check("short_abcd", {4'b0, A, B, C, D}, 8'h00);
    check("short_state", {6'b0, dut.u_deb.state_q}, {6'b0, IDLE});

    // Full frame 1,0,1,1.
    strobe_base = strobe_cnt;
    press(1'b1);
    press(1'b0);
    press(1'b1);
    check("frame3_abcd", {4'b0, A, B, C, D}, 8'h0A);
    check("frame3_valid", {7'b0, frame_valid}, 8'h00);
    press(1'b1);
    check("frame4_abcd", {4'b0, A, B, C, D}, 8'h0D);
    check("frame4_valid", {7'b0, frame_valid}, 8'h01);
    check("frame4_strobe_cnt", 8'(strobe_cnt - strobe_base), 8'h01);

    // Fifth press starts a new frame.
    strobe_base = strobe_cnt;
    press(1'b0);
    check("frame5_abcd", {4'b0, A, B, C, D}, 8'h06);
    check("frame5_count", {5'b0, dut.count_q}, 8'h01);
    check("frame5_valid", {7'b0, frame_valid}, 8'h00);
    check("frame5_no_strobe", 8'(strobe_cnt - strobe_base), 8'h00);

    // clr lands on the pulse cycle: pulse is discarded.
    din = 1'b1;
    btn = 1'b1;
    tick(6);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clrpulse_abcd", {4'b0, A, B, C, D}, 8'h00);
    check("clrpulse_count", {5'b0, dut.count_q}, 8'h00);
    tick(5);
    btn = 1'b0;
    tick(12);
    check("clrpulse_held", {4'b0, A, B, C, D}, 8'h00);
    press(1'b1);
    check("clrpulse_next_abcd", {4'b0, A, B, C, D}, 8'h08);
    check("clrpulse_next_count", {5'b0, dut.count_q}, 8'h01);

    // Long hold with bouncy release yields one shift only.
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    din = 1'b1;
    btn = 1'b1;
    tick(50);
    btn = 1'b0;
    tick(3);
    btn = 1'b1;
    tick(1);
    btn = 1'b0;
    tick(2);
    btn = 1'b1;
    tick(1);
    btn = 1'b0;
    tick(12);
    check("hold_abcd", {4'b0, A, B, C, D}, 8'h08);
    check("hold_count", {5'b0, dut.count_q}, 8'h01);
    check("hold_state", {6'b0, dut.u_deb.state_q}, {6'b0, IDLE});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
